// File: rtl/systolic_pkg.sv
// Shared constants, drain FSM state type and row-strobe helper for the systolic array,
// its operand feeder and the result drain controller.
package systolic_pkg;

   localparam int DIM = 5;
   localparam int DW  = 32;
   localparam int CW  = 8;
   localparam int RW  = $clog2(DIM);
   localparam int NPE = DIM * DIM;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      READ,
      WRITE,
      CAP,
      SEND,
      DONE
   } drain_state_t;

   // One bit per PE of row r; PE (r,c) sits at bit r*DIM + c.
   function automatic logic [NPE-1:0] row_mask(input logic [RW-1:0] r);
      logic [NPE-1:0] m;
      m = '0;
      for (int c = 0; c < DIM; c++) begin
         m[int'(r) * DIM + c] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Row-major result stream: one accumulator word per beat, tagged with its array coordinates.
interface systolic_result_drain_if;
   import systolic_pkg::*;

   logic [DW-1:0] m_data;
   logic [RW-1:0] m_row;
   logic [RW-1:0] m_col;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;

   modport master (
      output m_data, m_row, m_col, m_valid, m_last,
      input  m_ready
   );

   modport slave (
      input  m_data, m_row, m_col, m_valid, m_last,
      output m_ready
   );

endinterface

// File: rtl/systolic_result_drain_row_buf.sv
// Holds one captured row of accumulators and selects a single column word from it.
module drain_row_buf
   import systolic_pkg::*;
(
   input  logic                clk,
   input  logic                clr_n,
   input  logic                load,
   input  logic [DIM*DW-1:0]   row_in,
   input  logic [RW-1:0]       sel,
   output logic [DW-1:0]       word_out
);

   logic [DIM*DW-1:0] row_q;
   logic [DIM*DW-1:0] row_d;

   always_comb begin
      row_d = row_q;
      if (load) begin
         row_d = row_in;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         row_q <= '0;
      end else begin
         row_q <= row_d;
      end
   end

   always_comb begin
      word_out = '0;
      for (int c = 0; c < DIM; c++) begin
         if (int'(sel) == c) begin
            word_out = row_q[c*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/systolic_result_drain.sv
// Result drain controller: clears the array, waits out the operand wavefronts, then
// strobes, captures and streams each row of accumulators.
//
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | array accumulators cleared
//   FEED  | wait for k_len + 2*(DIM-1) wavefront cycles
//   READ  | read strobe on current row
//   WRITE | write strobe on current row
//   CAP   | res_in captured into row buffer
//   SEND  | stream DIM words of the current row
//   DONE  | job complete pulse
module systolic_result_drain
   import systolic_pkg::*;
(
   input  logic                         clk,
   input  logic                         clr_n,
   input  logic                         start,
   input  logic [CW-1:0]                k_len,
   output logic                         busy,
   output logic                         done,
   output logic [NPE-1:0]               arr_clr,
   output logic [NPE-1:0]               arr_read,
   output logic [NPE-1:0]               arr_write,
   input  logic [DIM*DW-1:0]            res_in,
   systolic_result_drain_if.master      m_if
);

   localparam logic [RW-1:0] LAST_IDX = RW'(DIM - 1);

   drain_state_t state_q, state_d;
   logic [CW:0]    wait_q, wait_d;
   logic [RW-1:0]  row_q, row_d;
   logic [RW-1:0]  col_q, col_d;
   logic           buf_load;
   logic [DW-1:0]  buf_word;

   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [NPE-1:0] arr_clr_q, arr_clr_d;
   logic [NPE-1:0] arr_read_q, arr_read_d;
   logic [NPE-1:0] arr_write_q, arr_write_d;
   logic [DW-1:0]  m_data_q, m_data_d;
   logic [RW-1:0]  m_row_q, m_row_d;
   logic [RW-1:0]  m_col_q, m_col_d;
   logic           m_valid_q, m_valid_d;
   logic           m_last_q, m_last_d;

   drain_row_buf u_row_buf (
      .clk      (clk),
      .clr_n    (clr_n),
      .load     (buf_load),
      .row_in   (res_in),
      .sel      (col_d),
      .word_out (buf_word)
   );

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      row_d    = row_q;
      col_d    = col_q;
      buf_load = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               wait_d  = {1'b0, k_len} + (CW+1)'(2 * (DIM - 1));
               row_d   = '0;
               col_d   = '0;
            end
         end
         CLEAR: state_d = FEED;
         FEED: begin
            if (wait_q <= (CW+1)'(1)) begin
               state_d = READ;
            end else begin
               wait_d = wait_q - (CW+1)'(1);
            end
         end
         READ:  state_d = WRITE;
         WRITE: state_d = CAP;
         CAP: begin
            buf_load = 1'b1;
            col_d    = '0;
            state_d  = SEND;
         end
         SEND: begin
            if (m_valid_q && m_if.m_ready) begin
               if (col_q == LAST_IDX) begin
                  col_d = '0;
                  if (row_q == LAST_IDX) begin
                     state_d = DONE;
                  end else begin
                     row_d   = row_q + RW'(1);
                     state_d = READ;
                  end
               end else begin
                  col_d = col_q + RW'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_comb begin
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      arr_clr_d   = (state_d == CLEAR) ? '1 : '0;
      arr_read_d  = (state_d == READ)  ? row_mask(row_d) : '0;
      arr_write_d = (state_d == WRITE) ? row_mask(row_d) : '0;
      m_valid_d   = (state_d == SEND);
      m_row_d     = row_d;
      m_col_d     = col_d;
      m_last_d    = (state_d == SEND) && (row_d == LAST_IDX) && (col_d == LAST_IDX);
      m_data_d    = m_data_q;
      // The buffer loads on the CAP edge, so the first word bypasses it.
      if (state_q == CAP) begin
         m_data_d = res_in[DW-1:0];
      end else if (state_d == SEND) begin
         m_data_d = buf_word;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         row_q       <= '0;
         col_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         arr_clr_q   <= '1;
         arr_read_q  <= '0;
         arr_write_q <= '0;
         m_data_q    <= '0;
         m_row_q     <= '0;
         m_col_q     <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         row_q       <= row_d;
         col_q       <= col_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         arr_clr_q   <= arr_clr_d;
         arr_read_q  <= arr_read_d;
         arr_write_q <= arr_write_d;
         m_data_q    <= m_data_d;
         m_row_q     <= m_row_d;
         m_col_q     <= m_col_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign arr_clr      = arr_clr_q;
   assign arr_read     = arr_read_q;
   assign arr_write    = arr_write_q;
   assign m_if.m_data  = m_data_q;
   assign m_if.m_row   = m_row_q;
   assign m_if.m_col   = m_col_q;
   assign m_if.m_valid = m_valid_q;
   assign m_if.m_last  = m_last_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for the result drain: a simple array model answers the strobes and
// expected words/strobes/timing come from the row-major drain rules.
module tb_systolic_result_drain;
   import systolic_pkg::*;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [RW-1:0] r;
      logic [RW-1:0] c;
      logic          last;
   } word_t;

   logic              clk = 1'b0;
   logic              clr_n;
   logic              start = 1'b0;
   logic [CW-1:0]     k_len = '0;
   logic              busy, done;
   logic [NPE-1:0]    arr_clr, arr_read, arr_write;
   logic [DIM*DW-1:0] res_in = '0;

   systolic_result_drain_if m_if();

   systolic_result_drain dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .start     (start),
      .k_len     (k_len),
      .busy      (busy),
      .done      (done),
      .arr_clr   (arr_clr),
      .arr_read  (arr_read),
      .arr_write (arr_write),
      .res_in    (res_in),
      .m_if      (m_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   word_t          exp_q[$];
   logic [NPE-1:0] rd_q[$];
   logic [NPE-1:0] wr_q[$];
   int             cyc, stalls, first_rd, exp_first_rd, exp_done_cyc;
   bit             active = 1'b0;
   bit             done_seen;
   bit             prev_stall;
   word_t          prev_w;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Array model: the row last write-strobed shows up on res_in the following cycle.
   always @(posedge clk) begin
      if (arr_write != '0) begin
         for (int r = 0; r < DIM; r++) begin
            if (arr_write[r*DIM]) begin
               for (int c = 0; c < DIM; c++) begin
                  res_in[c*DW +: DW] <= DW'(32'h100 * r + c);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      word_t w;
      if (active && clr_n) begin
         cyc++;
         chk("busy_in_job", busy, 1'b1);
         chk("arr_clr", arr_clr, (cyc == 1) ? {NPE{1'b1}} : {NPE{1'b0}});
         if (arr_read != '0) begin
            if (first_rd < 0) begin
               first_rd = cyc;
               chk("first_read_cycle", cyc, exp_first_rd);
            end
            if (rd_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL extra_read: got %0h expected none", arr_read);
            end else chk("arr_read", arr_read, rd_q.pop_front());
         end
         if (arr_write != '0) begin
            if (wr_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL extra_write: got %0h expected none", arr_write);
            end else chk("arr_write", arr_write, wr_q.pop_front());
         end
         w.d = m_if.m_data; w.r = m_if.m_row; w.c = m_if.m_col; w.last = m_if.m_last;
         if (prev_stall && m_if.m_valid) chk("stall_hold", w, prev_w);
         prev_stall = m_if.m_valid && !m_if.m_ready;
         prev_w = w;
         if (m_if.m_valid && !m_if.m_ready) stalls++;
         if (m_if.m_valid && m_if.m_ready) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL extra_word: got %0h expected none", w);
            end else chk("word", w, exp_q.pop_front());
         end
         if (done) begin
            chk("done_cycle", cyc, exp_done_cyc + stalls);
            chk("words_left", exp_q.size(), 0);
            done_seen = 1'b1;
            active = 1'b0;
         end
      end
   end

   task automatic chk_reset_outputs();
      chk("rst_arr_clr", arr_clr, {NPE{1'b1}});
      chk("rst_arr_read", arr_read, 0);
      chk("rst_arr_write", arr_write, 0);
      chk("rst_busy_done", {busy, done}, 0);
      chk("rst_valid_last", {m_if.m_valid, m_if.m_last}, 0);
      chk("rst_data_row_col", {m_if.m_data, m_if.m_row, m_if.m_col}, 0);
   endtask

   // mode 0: always ready, 1: 4-cycle stall on word (1,2), 2: random ready,
   // 3: start pulses while busy, 4: reset at word (2,1)
   task automatic run_job(input int k, input int mode);
      int n;
      int stall_cnt;
      bit aborted;
      exp_q.delete(); rd_q.delete(); wr_q.delete();
      for (int r = 0; r < DIM; r++) begin
         logic [NPE-1:0] m;
         m = {{(NPE-DIM){1'b0}}, {DIM{1'b1}}};
         m = m << (r * DIM);
         rd_q.push_back(m);
         wr_q.push_back(m);
         for (int c = 0; c < DIM; c++) begin
            word_t e;
            e.d = DW'(32'h100 * r + c);
            e.r = RW'(r);
            e.c = RW'(c);
            e.last = (r == DIM-1) && (c == DIM-1);
            exp_q.push_back(e);
         end
      end
      exp_first_rd = k + 2*(DIM-1) + 2;
      exp_done_cyc = k + 2*(DIM-1) + 2 + DIM*(3+DIM);
      stalls = 0; first_rd = -1; prev_stall = 1'b0; done_seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      k_len = CW'(k);
      m_if.m_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k_len = CW'($urandom);
      cyc = 0;
      active = 1'b1;
      n = 0; stall_cnt = 0; aborted = 1'b0;
      while (!done_seen && !aborted && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
         case (mode)
            1: begin
               if (m_if.m_valid && m_if.m_row == 1 && m_if.m_col == 2 && stall_cnt < 4) begin
                  m_if.m_ready = 1'b0;
                  stall_cnt++;
               end else m_if.m_ready = 1'b1;
            end
            2: m_if.m_ready = ($urandom_range(0, 3) != 0);
            3: begin
               if (cyc == 4 || cyc == 22) begin
                  start = 1'b1;
                  k_len = CW'(3);
               end else start = 1'b0;
            end
            4: begin
               if (m_if.m_valid && m_if.m_row == 2 && m_if.m_col == 1) begin
                  clr_n = 1'b0;
                  active = 1'b0;
                  aborted = 1'b1;
               end
            end
            default: m_if.m_ready = 1'b1;
         endcase
      end
      start = 1'b0;
      m_if.m_ready = 1'b1;
      if (aborted) begin
         #1;
         chk_reset_outputs();
         repeat (5) begin
            @(negedge clk);
            chk("no_done_in_reset", {done, busy}, 0);
         end
         clr_n = 1'b1;
         chk("aborted_no_done", done_seen, 1'b0);
      end else if (!done_seen) begin
         checks++; failures++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
         active = 1'b0;
      end else begin
         @(negedge clk);
         chk("idle_after_done", {busy, done}, 0);
      end
   endtask

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog: got no finish expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      clr_n = 1'b0;
      m_if.m_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         start = 1'($urandom);
         k_len = CW'($urandom);
         m_if.m_ready = 1'($urandom);
         #1;
         chk_reset_outputs();
      end
      start = 1'b0;
      m_if.m_ready = 1'b1;
      @(negedge clk);
      clr_n = 1'b1;
      @(posedge clk);
      #1;
      chk("release_arr_clr", arr_clr, 0);
      chk("release_busy", busy, 1'b0);

      run_job(9, 0);
      run_job(9, 1);
      run_job(9, 3);
      run_job(0, 0);
      run_job(9, 4);
      run_job(9, 0);
      run_job(255, 0);
      for (int i = 0; i < 4; i++) begin
         run_job($urandom_range(0, 40), 2);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
